// File: rtl/work_loader_pkg.sv
// Shared constants and FSM encoding for the work register load sequencer.
package work_loader_pkg;

   localparam int DEF_NUM_WORDS = 12;
   localparam int DEF_WORD_W    = 32;

   typedef logic [1:0] state_t;

   localparam state_t S_CLEAR  = 2'd0;
   localparam state_t S_LOAD   = 2'd1;
   localparam state_t S_COMMIT = 2'd2;
   localparam state_t S_HOLD   = 2'd3;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable; drives the per-register write enables.
module onehot_dec #(
   parameter int N     = 12,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   for (genvar i = 0; i < N; i++) begin : g_dec
      assign onehot[i] = en && (idx == IDX_W'(i));
   end

endmodule

// File: rtl/work_reg_loader.sv
// Steers a valid/ready word stream into the work register bank, one enable pulse per word.
// Optional checksum word and compare enabled by defining WORK_CKSUM_EN.
module work_reg_loader
   import work_loader_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int WORD_W    = DEF_WORD_W
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 in_valid,
   input  logic [WORD_W-1:0]    in_data,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [WORD_W-1:0]    reg_d,
   output logic [NUM_WORDS-1:0] reg_en,
   output logic                 reg_clr,
   output logic                 work_valid,
   input  logic                 work_ack,
   output logic                 err
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic                 accept;
   logic                 data_accept;
   logic [NUM_WORDS-1:0] en_next;

   assign reg_clr    = (state == S_CLEAR);
   assign work_valid = (state == S_HOLD);
   assign in_ready   = (state == S_LOAD) && !flush;
   assign accept     = in_valid && in_ready;

`ifdef WORK_CKSUM_EN
   logic              cksum_phase;
   logic              cksum_bad;
   logic [WORD_W-1:0] sum;

   // the trailing checksum word is consumed but never written to the bank
   assign data_accept = accept && !cksum_phase;
   assign err         = (state == S_COMMIT) && cksum_bad;
`else
   assign data_accept = accept;
   assign err         = 1'b0;
`endif

   onehot_dec #(.N(NUM_WORDS), .IDX_W(IDX_W)) u_dec (
      .en     (data_accept),
      .idx    (idx),
      .onehot (en_next)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= S_CLEAR;
         idx    <= '0;
         reg_d  <= '0;
         reg_en <= '0;
`ifdef WORK_CKSUM_EN
         cksum_phase <= 1'b0;
         cksum_bad   <= 1'b0;
         sum         <= '0;
`endif
      end else begin
         // a pulse registered last cycle always completes, even under flush
         reg_en <= en_next;
         if (data_accept) reg_d <= in_data;

         if (flush) begin
            state <= S_CLEAR;
            idx   <= '0;
         end else begin
            case (state)
               S_CLEAR: begin
                  idx   <= '0;
                  state <= S_LOAD;
`ifdef WORK_CKSUM_EN
                  sum         <= '0;
                  cksum_phase <= 1'b0;
`endif
               end
               S_LOAD: begin
`ifdef WORK_CKSUM_EN
                  if (accept) begin
                     if (cksum_phase) begin
                        cksum_bad   <= (in_data != sum);
                        cksum_phase <= 1'b0;
                        state       <= S_COMMIT;
                     end else begin
                        sum <= sum + in_data;
                        if (idx == LAST_IDX) begin
                           idx         <= '0;
                           cksum_phase <= 1'b1;
                        end else begin
                           idx <= idx + 1'b1;
                        end
                     end
                  end
`else
                  if (accept) begin
                     if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_COMMIT;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
`endif
               end
               S_COMMIT: begin
`ifdef WORK_CKSUM_EN
                  state <= cksum_bad ? S_CLEAR : S_HOLD;
`else
                  state <= S_HOLD;
`endif
               end
               S_HOLD: begin
                  if (work_ack) begin
                     state <= S_LOAD;
`ifdef WORK_CKSUM_EN
                     sum <= '0;
`endif
                  end
               end
               default: state <= S_CLEAR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_work_reg_loader.sv
// Scoreboard bench for work_reg_loader: expected (index, word) pushed at accept, popped on each reg_en pulse.
module tb_work_reg_loader;

   localparam int NW = 12;
   localparam int W  = 32;
`ifdef WORK_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          flush = 1'b0;
   logic          work_ack = 1'b0;
   logic          in_ready;
   logic [W-1:0]  reg_d;
   logic [NW-1:0] reg_en;
   logic          reg_clr;
   logic          work_valid;
   logic          err;

   always #5 clk = ~clk;

   work_reg_loader #(.NUM_WORDS(NW), .WORD_W(W)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .flush      (flush),
      .reg_d      (reg_d),
      .reg_en     (reg_en),
      .reg_clr    (reg_clr),
      .work_valid (work_valid),
      .work_ack   (work_ack),
      .err        (err)
   );

   typedef struct {
      int           idx;
      logic [W-1:0] data;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] bank[NW];
   int n_checks = 0, n_fail = 0;
   int cyc = 0, clr_cnt = 0, err_cnt = 0, acc_cyc = 0, acc_first = 0;
`ifdef WORK_CKSUM_EN
   int cks_delta = 0;
`endif

   always @(posedge clk) cyc++;

   // Monitor: bank model plus scoreboard pop on every enable pulse
   exp_t          m_e;
   logic [NW-1:0] m_oh;
   always @(posedge clk) begin
      #1;
      if (reg_clr) begin
         clr_cnt++;
         for (int i = 0; i < NW; i++) bank[i] = '0;
      end
      if (err) err_cnt++;
      if (reg_en != '0) begin
         n_checks++;
         if ($countones(reg_en) != 1) begin
            n_fail++;
            $display("FAIL onehot: reg_en=%b, required exactly one bit", reg_en);
         end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: reg_en=%b reg_d=%h, required no pulse", reg_en, reg_d);
         end else begin
            m_e  = sb.pop_front();
            m_oh = {{(NW-1){1'b0}}, 1'b1} << m_e.idx;
            n_checks++;
            if (reg_en !== m_oh || reg_d !== m_e.data) begin
               n_fail++;
               $display("FAIL pulse: reg_en=%b reg_d=%h, required reg_en=%b reg_d=%h",
                        reg_en, reg_d, m_oh, m_e.data);
            end
            bank[m_e.idx] = reg_d;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input int exp_idx);
      bit   done = 0;
      exp_t x;
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            if (exp_idx >= 0) begin
               x.idx  = exp_idx;
               x.data = d;
               sb.push_back(x);
            end
            if (exp_idx == 0) acc_first = cyc;
            acc_cyc = cyc;
            done    = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: word %h not accepted in 100 cycles", d);
      end
   endtask

   task automatic send_unit(input logic [W-1:0] base, input int gap_max);
      logic [W-1:0] s = '0;
      for (int i = 0; i < NW; i++) begin
         send(base + W'(i), i);
         s = s + base + W'(i);
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
      end
`ifdef WORK_CKSUM_EN
      send(s + W'(cks_delta), -1);
`else
      if (s == '1) $display("note: all-ones sum");
`endif
   endtask

   task automatic pulse_ack();
      work_ack = 1'b1;
      @(posedge clk);
      #1;
      work_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (reg_en !== '0 || work_valid !== 1'b0 || reg_clr !== 1'b1 || in_ready !== 1'b0 ||
          reg_d !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vals: en=%b wv=%b clr=%b rdy=%b d=%h err=%b, required 0 0 1 0 0 0",
                  reg_en, work_valid, reg_clr, in_ready, reg_d, err);
      end
      @(negedge clk);
      clr_n = 1'b1;
      #1;
      n_checks++;
      if (reg_clr !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_clr: reg_clr=%b, required 1", reg_clr);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (reg_clr !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_to_load: reg_clr=%b in_ready=%b, required 0 1", reg_clr, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      send_unit(32'h1, 0);
      n_checks++;
      if (acc_cyc - acc_first != NW - 1 + CK) begin
         n_fail++;
         $display("FAIL b2b_span: %0d cycles, required %0d", acc_cyc - acc_first, NW - 1 + CK);
      end
      n_checks++;
      if (work_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wv_early: work_valid=%b at t+1, required 0", work_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wv_t2: work_valid=%b in_ready=%b, required 1 0", work_valid, in_ready);
      end
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (bank[i] !== W'(i + 1)) begin
            n_fail++;
            $display("FAIL b2b_bank[%0d]: %h, required %h", i, bank[i], W'(i + 1));
         end
      end
   endtask

   task automatic test_hold_overwrite();
      int clr0;
      in_valid = 1'b1;
      in_data  = 32'h100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0 || work_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ready: in_ready=%b work_valid=%b, required 0 1", in_ready, work_valid);
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      clr0 = clr_cnt;
      pulse_ack();
      n_checks++;
      if (in_ready !== 1'b1 || work_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_to_load: in_ready=%b work_valid=%b, required 1 0", in_ready, work_valid);
      end
      send_unit(32'h100, 3);
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b1 || clr_cnt != clr0) begin
         n_fail++;
         $display("FAIL overwrite: work_valid=%b clr_cycles=%0d, required 1 0", work_valid, clr_cnt - clr0);
      end
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (bank[i] !== W'(32'h100 + i)) begin
            n_fail++;
            $display("FAIL ovw_bank[%0d]: %h, required %h", i, bank[i], W'(32'h100 + i));
         end
      end
   endtask

   task automatic test_random_gaps();
      pulse_ack();
      send_unit(32'h1, 4);
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_wv: work_valid=%b, required 1", work_valid);
      end
      for (int i = 0; i < NW; i++) begin
         n_checks++;
         if (bank[i] !== W'(i + 1)) begin
            n_fail++;
            $display("FAIL gaps_bank[%0d]: %h, required %h", i, bank[i], W'(i + 1));
         end
      end
   endtask

   task automatic test_flush();
      pulse_ack();
      for (int i = 0; i < 5; i++) send(32'h40 + W'(i), i);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
      end
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (reg_clr !== 1'b1 || reg_en !== '0) begin
         n_fail++;
         $display("FAIL flush_clr: reg_clr=%b reg_en=%b, required 1 0", reg_clr, reg_en);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (reg_clr !== 1'b0 || in_ready !== 1'b1 || bank[0] !== '0) begin
         n_fail++;
         $display("FAIL flush_after: reg_clr=%b in_ready=%b bank0=%h, required 0 1 0", reg_clr, in_ready, bank[0]);
      end
      send_unit(32'h200, 1);
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b1 || bank[0] !== 32'h200 || bank[NW-1] !== 32'h20B) begin
         n_fail++;
         $display("FAIL flush_reload: wv=%b bank0=%h bank11=%h, required 1 200 20b", work_valid, bank[0], bank[NW-1]);
      end
      flush    = 1'b1;
      work_ack = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      work_ack = 1'b0;
      n_checks++;
      if (reg_clr !== 1'b1 || work_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ack: reg_clr=%b work_valid=%b, required 1 0", reg_clr, work_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_ack_load: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_reset_midload();
      for (int i = 0; i < 3; i++) send(32'h70 + W'(i), i);
      #2;
      clr_n = 1'b0;
      #1;
      n_checks++;
      if (reg_en !== '0 || work_valid !== 1'b0 || reg_clr !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midload_rst: en=%b wv=%b clr=%b rdy=%b, required 0 0 1 0",
                  reg_en, work_valid, reg_clr, in_ready);
      end
      @(negedge clk);
      clr_n = 1'b1;
      #1;
      n_checks++;
      if (reg_clr !== 1'b1) begin
         n_fail++;
         $display("FAIL midload_release: reg_clr=%b, required 1", reg_clr);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || reg_clr !== 1'b0) begin
         n_fail++;
         $display("FAIL midload_load: in_ready=%b reg_clr=%b, required 1 0", in_ready, reg_clr);
      end
      send(32'h99, 0);
      @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0 || bank[0] !== 32'h99) begin
         n_fail++;
         $display("FAIL midload_restart: pending=%0d bank0=%h, required 0 99", sb.size(), bank[0]);
      end
   endtask

`ifdef WORK_CKSUM_EN
   task automatic test_cksum();
      int e0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(posedge clk);
      #1;
      e0 = err_cnt;
      cks_delta = 0;
      send_unit(32'h1, 0);
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b1 || err_cnt != e0) begin
         n_fail++;
         $display("FAIL cksum_good: work_valid=%b err_pulses=%0d, required 1 0", work_valid, err_cnt - e0);
      end
      pulse_ack();
      cks_delta = 1;
      send_unit(32'h1, 0);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL cksum_err: err=%b, required 1", err);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (err !== 1'b0 || reg_clr !== 1'b1 || work_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cksum_bad: err=%b clr=%b wv=%b, required 0 1 0", err, reg_clr, work_valid);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (work_valid !== 1'b0 || err_cnt != e0 + 1) begin
         n_fail++;
         $display("FAIL cksum_after: wv=%b err_pulses=%0d, required 0 1", work_valid, err_cnt - e0);
      end
      cks_delta = 0;
   endtask
`else
   task automatic test_no_err();
      n_checks++;
      if (err_cnt != 0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_tied: err pulses=%0d, required 0", err_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_hold_overwrite();
      test_random_gaps();
      test_flush();
      test_reset_midload();
`ifdef WORK_CKSUM_EN
      test_cksum();
`else
      test_no_err();
`endif
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d pulses missing, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
